// File: rtl/tt_bist_stimulus.sv
// tt_bist_stimulus: self-test driver for a tt_um_* user project.
// After start it holds the user design in reset for RST_CYCLES cycles. It then
// drives an 8-bit LFSR pattern on ui_in for LEN cycles and compacts uo_out into a
// 16-bit MISR signature. At the end it reports done, and pass if the signature
// equals EXPECTED.
// Ports:
//   clk, rst_n  - system clock, asynchronous active-low reset
//   start       - one-cycle pulse; honoured only in IDLE or DONE
//   dut_rst_n   - reset to the user design (active low)
//   dut_ena     - enable to the user design
//   dut_ui_in   - stimulus on the dedicated inputs
//   dut_uio_in  - constant UIO_VAL on the bidir inputs (0 while idle)
//   dut_uo_out  - response from the user design
//   busy        - high while in RST or RUN
//   done        - high in DONE
//   pass        - valid with done: signature == EXPECTED
//   signature   - current MISR value
module tt_bist_stimulus #(
    parameter int unsigned LEN        = 256,
    parameter int unsigned RST_CYCLES = 4,
    parameter logic [7:0]  SEED       = 8'h01,
    parameter logic [15:0] EXPECTED   = 16'h0000,
    parameter logic [7:0]  UIO_VAL    = 8'h00
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        dut_rst_n,
    output logic        dut_ena,
    output logic [7:0]  dut_ui_in,
    output logic [7:0]  dut_uio_in,
    input  logic [7:0]  dut_uo_out,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] signature
);

    localparam int unsigned CNT_W = 16;
    localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] RUN_LAST = CNT_W'(LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RST,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [7:0]       lfsr;
    logic [7:0]       lfsr_next;
    logic [15:0]      misr_next;

    // Next LFSR pattern and next MISR value with the current response folded in.
    always_comb begin
        lfsr_next = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        misr_next = {signature[14:0], signature[15] ^ signature[13] ^ signature[12] ^ signature[10]}
                    ^ {8'h00, dut_uo_out};
    end

    // Sequencer: state, counter, LFSR, MISR and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            cnt        <= '0;
            lfsr       <= '0;
            dut_rst_n  <= 1'b0;
            dut_ena    <= 1'b0;
            dut_ui_in  <= '0;
            dut_uio_in <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            signature  <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    // Start (or restart): MISR cleared, LFSR reseeded, user design held in reset.
                    if (start) begin
                        state      <= S_RST;
                        cnt        <= '0;
                        lfsr       <= SEED;
                        signature  <= '0;
                        dut_rst_n  <= 1'b0;
                        dut_ena    <= 1'b1;
                        dut_ui_in  <= '0;
                        dut_uio_in <= UIO_VAL;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        pass       <= 1'b0;
                    end
                end
                S_RST: begin
                    if (cnt == RST_LAST) begin
                        // Release reset; the seed is the first pattern presented.
                        state     <= S_RUN;
                        cnt       <= '0;
                        dut_rst_n <= 1'b1;
                        dut_ui_in <= lfsr;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_RUN: begin
                    // Sample the response to the pattern on the pins, then advance.
                    signature <= misr_next;
                    if (cnt == RUN_LAST) begin
                        // Last sample: freeze signature and hold the final pattern.
                        state <= S_DONE;
                        cnt   <= '0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (misr_next == EXPECTED);
                    end else begin
                        cnt       <= cnt + CNT_W'(1);
                        lfsr      <= lfsr_next;
                        dut_ui_in <= lfsr_next;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tt_bist_stimulus.sv
// Bench for tt_bist_stimulus. Instance a uses LEN=256, RST_CYCLES=4 and a
// selectable user-design response. Instance b uses LEN=1, RST_CYCLES=1 with an
// echo user design.
module tb_tt_bist_stimulus;

    localparam int unsigned LEN_A  = 256;
    localparam int unsigned RC_A   = 4;
    localparam logic [7:0]  SEED_A = 8'h01;
    localparam logic [7:0]  UIO_A  = 8'h3C;
    localparam logic [7:0]  UIO_B  = 8'hA5;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_a, start_b;
    logic        rst_a, ena_a, busy_a, done_a, pass_a;
    logic [7:0]  ui_a, uio_a, uo_a;
    logic [15:0] sig_a;
    logic        rst_b, ena_b, busy_b, done_b, pass_b;
    logic [7:0]  ui_b, uio_b, uo_b;
    logic [15:0] sig_b;

    int          errors = 0;
    int          checks = 0;
    int          mode   = 0;
    logic [7:0]  key    = 8'h00;

    always #5 clk = ~clk;

    // Behaviour of the emulated user design for instance a.
    function automatic logic [7:0] resp(input int m, input logic [7:0] k, input logic [7:0] p);
        case (m)
            0:       return 8'h00;
            1:       return p;
            2:       return p ^ k;
            default: return {p[3:0], p[7:4]} + k;
        endcase
    endfunction

    assign uo_a = resp(mode, key, ui_a);
    assign uo_b = ui_b;

    tt_bist_stimulus #(
        .LEN(LEN_A), .RST_CYCLES(RC_A), .SEED(SEED_A), .EXPECTED(16'h0000), .UIO_VAL(UIO_A)
    ) u_dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a),
        .dut_rst_n(rst_a), .dut_ena(ena_a), .dut_ui_in(ui_a), .dut_uio_in(uio_a),
        .dut_uo_out(uo_a), .busy(busy_a), .done(done_a), .pass(pass_a), .signature(sig_a)
    );

    tt_bist_stimulus #(
        .LEN(1), .RST_CYCLES(1), .SEED(8'h01), .EXPECTED(16'h0000), .UIO_VAL(UIO_B)
    ) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b),
        .dut_rst_n(rst_b), .dut_ena(ena_b), .dut_ui_in(ui_b), .dut_uio_in(uio_b),
        .dut_uo_out(uo_b), .busy(busy_b), .done(done_b), .pass(pass_b), .signature(sig_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One full test on instance a. The expected patterns and signature come from the
    // LFSR/MISR rules (parity of tapped bits). With inject set, start is also pulsed
    // during RUN, and those pulses must be ignored.
    task automatic run_a(input bit inject);
        logic [7:0]  pat [LEN_A];
        logic [7:0]  p;
        logic [15:0] s;
        int          n;
        int          idx;
        int          low;
        p = SEED_A;
        s = 16'h0000;
        for (int k = 0; k < int'(LEN_A); k++) begin
            pat[k] = p;
            s = {s[14:0], ^(s & 16'hB400)} ^ {8'h00, resp(mode, key, p)};
            p = {p[6:0], ^(p & 8'hB8)};
        end
        low = 0;
        @(negedge clk);
        start_a = 1'b1;
        for (n = 1; n <= 2000; n++) begin
            @(posedge clk);
            #1;
            start_a = inject && (n > int'(RC_A)) && (n + 5 < int'(RC_A + LEN_A)) && (n % 29 == 0);
            if (n == 1) begin
                check("rst_entry_busy", 32'(busy_a), 32'd1);
                check("rst_entry_done", 32'(done_a), 32'd0);
                check("rst_entry_pass", 32'(pass_a), 32'd0);
                check("rst_entry_sig", 32'(sig_a), 32'd0);
                check("rst_entry_ena", 32'(ena_a), 32'd1);
                check("rst_entry_ui", 32'(ui_a), 32'd0);
                check("rst_entry_uio", 32'(uio_a), 32'(UIO_A));
            end
            if (busy_a && !rst_a) begin
                low++;
            end else if (busy_a) begin
                idx = n - int'(RC_A) - 1;
                if (idx >= 0 && idx < int'(LEN_A))
                    check("run_ui", 32'(ui_a), 32'(pat[idx]));
                else
                    check("run_window", 32'(n), 32'(RC_A + LEN_A));
            end
            if (done_a) break;
        end
        start_a = 1'b0;
        check("done_seen", 32'(done_a), 32'd1);
        check("done_cycles", 32'(n), 32'(RC_A + LEN_A + 1));
        check("rst_low_cycles", 32'(low), 32'(RC_A));
        check("signature", 32'(sig_a), 32'(s));
        check("pass", 32'(pass_a), 32'(s == 16'h0000));
        check("done_ui_hold", 32'(ui_a), 32'(pat[LEN_A-1]));
        check("done_busy", 32'(busy_a), 32'd0);
        check("done_dut_rst", 32'(rst_a), 32'd1);
        check("done_ena", 32'(ena_a), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        check("sig_frozen", 32'(sig_a), 32'(s));
        check("done_held", 32'(done_a), 32'd1);
    endtask

    initial begin
        int n;
        rst_n   = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", 32'(busy_a), 32'd0);
        check("reset_dut_rst", 32'(rst_a), 32'd0);
        check("reset_sig", 32'(sig_a), 32'd0);
        check("reset_done_b", 32'(done_b), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("idle_ena", 32'(ena_a), 32'd0);
        check("idle_uio", 32'(uio_a), 32'd0);
        check("idle_ui", 32'(ui_a), 32'd0);

        // Zero-response user design: signature 0000, pass, 261-cycle run.
        mode = 0;
        run_a(1'b0);
        // Rerun from DONE reproduces the same result.
        run_a(1'b0);
        // Extra start pulses during RUN change nothing.
        run_a(1'b1);

        // Randomized user-design responses.
        repeat (4) begin
            mode = int'($urandom_range(0, 3));
            key  = 8'($urandom);
            run_a(1'($urandom_range(0, 1)));
        end

        // Asynchronous reset in the middle of RUN.
        mode = 1;
        @(negedge clk);
        start_a = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("midrun_busy", 32'(busy_a), 32'd1);
        rst_n = 1'b0;
        #1;
        check("async_rst_busy", 32'(busy_a), 32'd0);
        check("async_rst_done", 32'(done_a), 32'd0);
        check("async_rst_pass", 32'(pass_a), 32'd0);
        check("async_rst_sig", 32'(sig_a), 32'd0);
        check("async_rst_dut_rst", 32'(rst_a), 32'd0);
        check("async_rst_ena", 32'(ena_a), 32'd0);
        check("async_rst_ui", 32'(ui_a), 32'd0);
        check("async_rst_uio", 32'(uio_a), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("post_rst_idle_busy", 32'(busy_a), 32'd0);
        check("post_rst_idle_done", 32'(done_a), 32'd0);
        check("post_rst_idle_ena", 32'(ena_a), 32'd0);

        // Minimum configuration with an echo user design: LEN=1, RST_CYCLES=1.
        @(negedge clk);
        start_b = 1'b1;
        for (n = 1; n <= 50; n++) begin
            @(posedge clk);
            #1;
            start_b = 1'b0;
            if (n == 1) begin
                check("b_rst_entry_dut_rst", 32'(rst_b), 32'd0);
                check("b_uio", 32'(uio_b), 32'(UIO_B));
            end
            if (n == 2) check("b_first_pattern", 32'(ui_b), 32'h01);
            if (done_b) break;
        end
        check("b_done_seen", 32'(done_b), 32'd1);
        check("b_done_cycles", 32'(n), 32'd3);
        check("b_signature", 32'(sig_b), 32'h0001);
        check("b_pass", 32'(pass_b), 32'd0);
        check("b_ui_hold", 32'(ui_b), 32'h01);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
